// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator for a byte-wide synchronous data memory.
// Define LSU_MISALIGN_TRAP_EN to trap unaligned HALF/WORD accesses instead of splitting them.

module load_store_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LS_SEL_WIDTH = 3
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Req_Valid,
  output logic                  o_Req_Ready,
  input  logic [LS_SEL_WIDTH:0] i_Load_Store_Type,
  input  logic [XLEN-1:0]       i_Addr,
  input  logic [XLEN-1:0]       i_Data,
  output logic                  o_Resp_Valid,
  output logic [XLEN-1:0]       o_Resp_Data,
  output logic                  o_Resp_Error,
  output logic [XLEN-1:0]       o_Mem_Addr,
  output logic [7:0]            o_Mem_Data,
  output logic                  o_Mem_Write_Enable,
  input  logic [7:0]            i_Mem_Data
);

  typedef logic [LS_SEL_WIDTH:0] ls_type_t;

  // Bit 3 selects store, bit 2 selects unsigned, bits 1:0 give the size.
  localparam ls_type_t LS_TYPE_LOAD_BYTE          = ls_type_t'(0);
  localparam ls_type_t LS_TYPE_LOAD_HALF          = ls_type_t'(1);
  localparam ls_type_t LS_TYPE_LOAD_WORD          = ls_type_t'(2);
  localparam ls_type_t LS_TYPE_LOAD_BYTE_UNSIGNED = ls_type_t'(4);
  localparam ls_type_t LS_TYPE_LOAD_HALF_UNSIGNED = ls_type_t'(5);
  localparam ls_type_t LS_TYPE_STORE_BYTE         = ls_type_t'(8);
  localparam ls_type_t LS_TYPE_STORE_HALF         = ls_type_t'(9);
  localparam ls_type_t LS_TYPE_STORE_WORD         = ls_type_t'(10);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

  // Zero marks an unrecognised type.
  function automatic logic [2:0] beat_count(input ls_type_t t);
    logic [2:0] n;
    case (t)
      LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_STORE_BYTE: n = 3'd1;
      LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_HALF: n = 3'd2;
      LS_TYPE_LOAD_WORD, LS_TYPE_STORE_WORD:                            n = 3'd4;
      default:                                                          n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_store(input ls_type_t t);
    return (t == LS_TYPE_STORE_BYTE) || (t == LS_TYPE_STORE_HALF) || (t == LS_TYPE_STORE_WORD);
  endfunction

  function automatic logic is_unsigned(input ls_type_t t);
    return (t == LS_TYPE_LOAD_BYTE_UNSIGNED) || (t == LS_TYPE_LOAD_HALF_UNSIGNED);
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input ls_type_t t);
    logic [XLEN-1:0] r;
    logic            fill;
    r = raw;
    case (beat_count(t))
      3'd1: begin
        fill = ~is_unsigned(t) & raw[7];
        r    = {{(XLEN-8){fill}}, raw[7:0]};
      end
      3'd2: begin
        fill = ~is_unsigned(t) & raw[15];
        r    = {{(XLEN-16){fill}}, raw[15:0]};
      end
      default: r = raw;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input ls_type_t t, input logic [1:0] a);
    return ((beat_count(t) == 3'd2) && a[0]) || ((beat_count(t) == 3'd4) && (a != 2'b00));
  endfunction
`endif

  state_e          state_q, state_d;
  ls_type_t        type_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [1:0]      count_q, count_d;
  logic [XLEN-1:0] lanes_q, lanes_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            resp_err_q, resp_err_d;
`endif

  logic [2:0]      beats;
  logic            last_beat;
  logic [1:0]      final_lane;
  logic [XLEN-1:0] load_full;

  assign beats      = beat_count(type_q);
  assign last_beat  = ({1'b0, count_q} == (beats - 3'd1));
  assign final_lane = 2'(beats - 3'd1);

  // The last byte is still on the bus in DRAIN, so merge it straight into the result.
  always_comb begin
    load_full                       = lanes_q;
    load_full[8*final_lane +: 8]    = i_Mem_Data;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lanes_d     = lanes_q;
    resp_data_d = resp_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    resp_err_d  = resp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_Req_Valid) begin
          count_d = '0;
          lanes_d = '0;
          state_d = StXfer;
          if (beat_count(i_Load_Store_Type) == 3'd0) begin
            state_d     = StDone;
            resp_data_d = '0;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          resp_err_d = 1'b0;
          if (misaligned(i_Load_Store_Type, i_Addr[1:0])) begin
            state_d     = StDone;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end
`endif
        end
      end
      StXfer: begin
        // Read data lags the address by one cycle: beat k returns byte k-1.
        if (!is_store(type_q) && (count_q != 2'd0)) begin
          lanes_d[8*(count_q-2'd1) +: 8] = i_Mem_Data;
        end
        if (last_beat) begin
          if (is_store(type_q)) begin
            state_d     = StDone;
            resp_data_d = '0;
          end else begin
            state_d = StDrain;
          end
        end else begin
          count_d = count_q + 2'd1;
        end
      end
      StDrain: begin
        lanes_d     = load_full;
        resp_data_d = extend(load_full, type_q);
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      type_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      lanes_q     <= '0;
      resp_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lanes_q     <= lanes_d;
      resp_data_q <= resp_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q  <= resp_err_d;
`endif
      if ((state_q == StIdle) && i_Req_Valid) begin
        type_q <= i_Load_Store_Type;
        addr_q <= i_Addr;
        data_q <= i_Data;
      end
    end
  end

  always_comb begin
    o_Req_Ready        = (state_q == StIdle);
    o_Resp_Valid       = (state_q == StDone);
    o_Resp_Data        = resp_data_q;
    o_Mem_Write_Enable = 1'b0;
    o_Mem_Addr         = '0;
    o_Mem_Data         = '0;
    if (state_q == StXfer) begin
      o_Mem_Addr = addr_q + XLEN'(count_q);
      if (is_store(type_q)) begin
        o_Mem_Write_Enable = 1'b1;
        o_Mem_Data         = data_q[8*count_q +: 8];
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign o_Resp_Error = resp_err_q;
`else
  assign o_Resp_Error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a transaction-level model predicts every bus beat
// and response cycle; a 256-byte memory (address bits 7:0) answers the DUT's bus.

module tb_load_store_unit;

  localparam logic [3:0] T_LB  = 4'd0;
  localparam logic [3:0] T_LH  = 4'd1;
  localparam logic [3:0] T_LW  = 4'd2;
  localparam logic [3:0] T_LBU = 4'd4;
  localparam logic [3:0] T_LHU = 4'd5;
  localparam logic [3:0] T_SB  = 4'd8;
  localparam logic [3:0] T_SH  = 4'd9;
  localparam logic [3:0] T_SW  = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        i_Req_Valid = 1'b0;
  logic [3:0]  i_Load_Store_Type = '0;
  logic [31:0] i_Addr = '0;
  logic [31:0] i_Data = '0;
  logic        o_Req_Ready, o_Resp_Valid, o_Resp_Error, o_Mem_Write_Enable;
  logic [31:0] o_Resp_Data, o_Mem_Addr;
  logic [7:0]  o_Mem_Data;
  logic [7:0]  rd_q;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .LS_SEL_WIDTH(3)) dut (
    .i_Clock            (clk),
    .i_Reset            (rst),
    .i_Req_Valid        (i_Req_Valid),
    .o_Req_Ready        (o_Req_Ready),
    .i_Load_Store_Type  (i_Load_Store_Type),
    .i_Addr             (i_Addr),
    .i_Data             (i_Data),
    .o_Resp_Valid       (o_Resp_Valid),
    .o_Resp_Data        (o_Resp_Data),
    .o_Resp_Error       (o_Resp_Error),
    .o_Mem_Addr         (o_Mem_Addr),
    .o_Mem_Data         (o_Mem_Data),
    .o_Mem_Write_Enable (o_Mem_Write_Enable),
    .i_Mem_Data         (rd_q)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) bus_mem[i] <= init_byte(i);
    end else if (o_Mem_Write_Enable) begin
      bus_mem[o_Mem_Addr[7:0]] <= o_Mem_Data;
    end
    rd_q <= bus_mem[o_Mem_Addr[7:0]];
  end

  typedef struct {
    bit          we;
    bit          chk_addr;
    logic [31:0] addr;
    logic [7:0]  data;
    bit          resp;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_cnt = 0;
  int          free_edge = 0;
  int          accept_edge = 0;
  int          acc_count = 0;
  int          resp_count = 0;
  bit          resp_seen = 0;
  logic [31:0] obs_data;
  logic        obs_err;
  int          obs_lat;
  logic [31:0] last_rdata = '0;
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_mdata[$];
  logic        obs_we[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no DUT event within budget, wanted one (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(input bit we, input bit ca, input logic [31:0] a,
                              input logic [7:0] d, input bit r, input logic [31:0] rd,
                              input bit e);
    exp_t x;
    x.we = we; x.chk_addr = ca; x.addr = a; x.data = d;
    x.resp = r; x.rdata = rd; x.err = e;
    return x;
  endfunction

  // Transaction-level prediction: one entry per cycle after the accept edge.
  task automatic build(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    int          n;
    bit          st, us, ok;
    logic [31:0] v;
    ok = 1; st = 0; us = 0; n = 0;
    case (t)
      T_LB:  n = 1;
      T_LH:  n = 2;
      T_LW:  n = 4;
      T_LBU: begin n = 1; us = 1; end
      T_LHU: begin n = 2; us = 1; end
      T_SB:  begin n = 1; st = 1; end
      T_SH:  begin n = 2; st = 1; end
      T_SW:  begin n = 4; st = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      exp_q.push_back(mk(0, 0, '0, '0, 1, '0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    end else if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
      exp_q.push_back(mk(0, 0, '0, '0, 1, '0, 1));
`endif
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk(st, 1, a + 32'(k), 8'(d >> (8 * k)), 0, '0, 0));
        v = v + (32'(ref_mem[8'(a + 32'(k))]) << (8 * k));
      end
      if (!st) begin
        exp_q.push_back(mk(0, 0, '0, '0, 0, '0, 0));
        if (!us && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
      end else begin
        v = '0;
      end
      exp_q.push_back(mk(0, 0, '0, '0, 1, v, 0));
    end
  endtask

  // Acceptance model: a request is taken on the first edge the unit is free.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        free_edge = edge_cnt + 1;
      end else if (i_Req_Valid && edge_cnt >= free_edge) begin
        accept_edge = edge_cnt;
        resp_seen   = 0;
        obs_addr.delete();
        obs_mdata.delete();
        obs_we.delete();
        build(i_Load_Store_Type, i_Addr, i_Data);
        free_edge = edge_cnt + exp_q.size() + 1;
        acc_count++;
      end
    end
  end

  // Per-cycle comparison against the predicted schedule.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_init) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
      end
      if (rst) begin
        exp_q.delete();
        last_rdata = '0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("req_ready_busy", 32'(o_Req_Ready), 32'd0);
          chk("resp_valid", 32'(o_Resp_Valid), 32'(e.resp));
          chk("mem_we", 32'(o_Mem_Write_Enable), 32'(e.we));
          if (e.chk_addr) chk("mem_addr", o_Mem_Addr, e.addr);
          if (e.we) begin
            chk("mem_data", 32'(o_Mem_Data), 32'(e.data));
            ref_mem[e.addr[7:0]] = e.data;
          end
          if (e.resp) begin
            chk("resp_data", o_Resp_Data, e.rdata);
            chk("resp_err", 32'(o_Resp_Error), 32'(e.err));
            last_rdata = e.rdata;
          end else begin
            chk("resp_hold", o_Resp_Data, last_rdata);
          end
        end else begin
          chk("req_ready_idle", 32'(o_Req_Ready), 32'd1);
          chk("resp_valid_idle", 32'(o_Resp_Valid), 32'd0);
          chk("mem_we_idle", 32'(o_Mem_Write_Enable), 32'd0);
          chk("resp_hold_idle", o_Resp_Data, last_rdata);
        end
        if (o_Resp_Valid) begin
          resp_seen = 1;
          obs_data  = o_Resp_Data;
          obs_err   = o_Resp_Error;
          obs_lat   = edge_cnt - accept_edge + 1;
          resp_count++;
        end else if (!o_Req_Ready) begin
          obs_addr.push_back(o_Mem_Addr);
          obs_mdata.push_back(o_Mem_Data);
          obs_we.push_back(o_Mem_Write_Enable);
        end
      end
    end
  end

  task automatic wait_accept(input int a0);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_count != a0) got = 1;
    end
    if (!got) timeout("accept");
  endtask

  task automatic send(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    int a0;
    a0 = acc_count;
    i_Load_Store_Type = t;
    i_Addr            = a;
    i_Data            = d;
    i_Req_Valid       = 1'b1;
    wait_accept(a0);
    i_Req_Valid = 1'b0;
    for (int i = 0; i < 20 && !resp_seen; i++) begin
      @(negedge clk);
      #1;
    end
    if (!resp_seen) timeout("response");
  endtask

  initial begin
    logic [31:0] t1_addr[4];
    logic [7:0]  t1_data[4];
    logic [31:0] t4_addr[4];
    logic [3:0]  tlist[10];
    logic [31:0] a;
    int          r0, a0, mism;

    t1_addr = '{32'h10, 32'h11, 32'h12, 32'h13};
    t1_data = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    t4_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    tlist   = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW, 4'd3, 4'd15};

    #2;
    chk("rst_ready", 32'(o_Req_Ready), 32'd1);
    chk("rst_resp_valid", 32'(o_Resp_Valid), 32'd0);
    chk("rst_resp_data", o_Resp_Data, 32'd0);
    chk("rst_resp_err", 32'(o_Resp_Error), 32'd0);
    chk("rst_we", 32'(o_Mem_Write_Enable), 32'd0);
    chk("rst_mem_addr", o_Mem_Addr, 32'd0);
    chk("rst_mem_data", 32'(o_Mem_Data), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Word store: four write beats, low byte first.
    send(T_SW, 32'h10, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(obs_lat), 32'd5);
    chk("t1_beats", 32'(obs_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk("t1_addr", obs_addr[i], t1_addr[i]);
      chk("t1_byte", 32'(obs_mdata[i]), 32'(t1_data[i]));
      chk("t1_we", 32'(obs_we[i]), 32'd1);
    end

    // Byte loads: sign and zero extension.
    send(T_SB, 32'h20, 32'h80);
    send(T_LB, 32'h20, 32'h0);
    chk("t2_lb_data", obs_data, 32'hFFFF_FF80);
    chk("t2_lb_latency", 32'(obs_lat), 32'd3);
    send(T_LBU, 32'h20, 32'h0);
    chk("t2_lbu_data", obs_data, 32'h0000_0080);
    chk("t2_lbu_latency", 32'(obs_lat), 32'd3);

    // Unaligned half load.
    send(T_SB, 32'h31, 32'h34);
    send(T_SB, 32'h32, 32'h92);
    send(T_LH, 32'h31, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t3_data", obs_data, 32'h0);
    chk("t3_err", 32'(obs_err), 32'd1);
    chk("t3_latency", 32'(obs_lat), 32'd1);
    chk("t3_beats", 32'(obs_addr.size()), 32'd0);
`else
    chk("t3_data", obs_data, 32'hFFFF_9234);
    chk("t3_err", 32'(obs_err), 32'd0);
    chk("t3_latency", 32'(obs_lat), 32'd4);
`endif

    // Word load across the top of the address space.
    send(T_LW, 32'hFFFF_FFFE, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t4_err", 32'(obs_err), 32'd1);
    chk("t4_latency", 32'(obs_lat), 32'd1);
`else
    chk("t4_latency", 32'(obs_lat), 32'd6);
    chk("t4_data", obs_data, 32'h300B_E6C1);
    chk("t4_beats", 32'(obs_addr.size()), 32'd5);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("t4_addr", obs_addr[i], t4_addr[i]);
`endif

    // Valid held high through the busy period: exactly one acceptance.
    r0 = resp_count;
    a0 = acc_count;
    i_Load_Store_Type = T_SW;
    i_Addr            = 32'h50;
    i_Data            = 32'h1122_3344;
    i_Req_Valid       = 1'b1;
    wait_accept(a0);
    repeat (5) @(posedge clk);
    #1;
    i_Req_Valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_responses", 32'(resp_count - r0), 32'd1);

    // Reset after two beats of a word store.
    r0 = resp_count;
    a0 = acc_count;
    i_Load_Store_Type = T_SW;
    i_Addr            = 32'h40;
    i_Data            = 32'hA1B2_C3D4;
    i_Req_Valid       = 1'b1;
    wait_accept(a0);
    i_Req_Valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_we_drop", 32'(o_Mem_Write_Enable), 32'd0);
    chk("t6_ready", 32'(o_Req_Ready), 32'd1);
    chk("t6_resp_valid", 32'(o_Resp_Valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_byte0", 32'(bus_mem[8'h40]), 32'hD4);
    chk("t6_byte1", 32'(bus_mem[8'h41]), 32'hC3);
    chk("t6_byte2", 32'(bus_mem[8'h42]), 32'h95);
    chk("t6_byte3", 32'(bus_mem[8'h43]), 32'hBA);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_resp", 32'(resp_count - r0), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      send(tlist[$urandom_range(0, 9)], a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 256; i++) if (bus_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
